// File: rtl/game_step_scheduler.sv
// game_step_scheduler: issues paced step requests while the game is in PLAY,
// commits the latched player direction per step, tracks speed level and stalls.
module game_step_scheduler #(
  parameter logic [2:0]  PLAY_STATE  = 3'd2,
  parameter int unsigned BASE_PERIOD = 12_500_000,
  parameter int unsigned PERIOD_DEC  = 500_000,
  parameter int unsigned MIN_PERIOD  = 2_500_000,
  parameter int unsigned LEVEL_W     = 4,
  parameter int unsigned TIMEOUT     = 1_000_000
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [2:0]         iState,
  input  logic               iKey_up,
  input  logic               iKey_down,
  input  logic               iKey_left,
  input  logic               iKey_right,
  input  logic               iScore_evt,
  input  logic               iLevel_clr,
  input  logic               iStep_done,
  output logic               oStep_req,
  output logic [1:0]         oDir,
  output logic [LEVEL_W-1:0] oLevel,
  output logic               oBusy,
  output logic               oStall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_REQ
  } state_t;

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;

  localparam logic [31:0] BASE_W = 32'(BASE_PERIOD);
  localparam logic [31:0] DEC_W  = 32'(PERIOD_DEC);
  localparam logic [31:0] MIN_W  = 32'(MIN_PERIOD);
  localparam logic [31:0] SPAN_W = BASE_W - MIN_W;
  localparam logic [31:0] TO_W   = 32'(TIMEOUT);

  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        wait_q, wait_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         pend_q, pend_d;
  logic               req_q, req_d;
  logic               stall_q, stall_d;

  logic [31:0] dec_amt;
  logic [31:0] period;
  logic [1:0]  cand;
  logic        key_any;
  logic        play;

  assign play = (iState == PLAY_STATE);

  always_comb begin
    dec_amt = 32'(level_q) * DEC_W;
    if (dec_amt >= SPAN_W) begin
      period = MIN_W;
    end else begin
      period = BASE_W - dec_amt;
    end
  end

  // Only the top-priority key is a candidate; a reversal is dropped.
  always_comb begin
    key_any = iKey_up | iKey_down | iKey_left | iKey_right;
    if (iKey_up) begin
      cand = D_UP;
    end else if (iKey_down) begin
      cand = D_DOWN;
    end else if (iKey_left) begin
      cand = D_LEFT;
    end else begin
      cand = D_RIGHT;
    end
    pend_d = pend_q;
    if (key_any && (cand != {dir_q[1], ~dir_q[0]})) begin
      pend_d = cand;
    end
  end

  always_comb begin
    level_d = level_q;
    if (iLevel_clr) begin
      level_d = '0;
    end else if (iScore_evt && (level_q != LVL_MAX)) begin
      level_d = level_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    req_d   = req_q;
    dir_d   = dir_q;
    stall_d = stall_q;
    unique case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (!play) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= period - 32'd1) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          dir_d   = pend_q;
          wait_d  = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_REQ: begin
        if (iStep_done) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = play ? S_COUNT : S_IDLE;
        end else if (wait_q != TO_W) begin
          wait_d = wait_q + 32'd1;
          if (wait_q == TO_W - 32'd1) begin
            stall_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      level_q <= '0;
      dir_q   <= D_RIGHT;
      pend_q  <= D_RIGHT;
      req_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      stall_q <= stall_d;
    end
  end

  assign oStep_req = req_q;
  assign oDir      = dir_q;
  assign oLevel    = level_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oStall    = stall_q;

endmodule

// File: tb/tb_game_step_scheduler.sv
// tb_game_step_scheduler: directed stimulus with a cycle-level reference
// model of the step scheduler compared against the DUT every cycle.
module tb_game_step_scheduler;

  localparam int BASE = 10;
  localparam int DEC  = 2;
  localparam int MINP = 4;
  localparam int TO   = 8;
  localparam int LW   = 3;
  localparam logic [2:0] PLAY = 3'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, key_u, key_d, key_l, key_r;
  logic          score, lclr, done;
  logic [2:0]    st;
  logic          req, busy, stall;
  logic [1:0]    dir;
  logic [LW-1:0] lvl;

  int n_cmp = 0;
  int n_bad = 0;

  game_step_scheduler #(
    .PLAY_STATE (PLAY),
    .BASE_PERIOD(BASE),
    .PERIOD_DEC (DEC),
    .MIN_PERIOD (MINP),
    .LEVEL_W    (LW),
    .TIMEOUT    (TO)
  ) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iState    (st),
    .iKey_up   (key_u),
    .iKey_down (key_d),
    .iKey_left (key_l),
    .iKey_right(key_r),
    .iScore_evt(score),
    .iLevel_clr(lclr),
    .iStep_done(done),
    .oStep_req (req),
    .oDir      (dir),
    .oLevel    (lvl),
    .oBusy     (busy),
    .oStall    (stall)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 counting, 2 requesting.
  int m_mode, m_cnt, m_wait, m_lvl, m_dir, m_pend;
  bit m_stall;
  bit m_valid = 1'b0;
  int opp[4] = '{1, 0, 3, 2};

  function automatic int period_of(input int l);
    if (l * DEC >= BASE - MINP) return MINP;
    return BASE - l * DEC;
  endfunction

  function automatic int first_key();
    if (key_u) return 0;
    if (key_d) return 1;
    if (key_l) return 2;
    if (key_r) return 3;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int c;
    int per;
    int pend_old;
    bit play;
    play = (st == PLAY);
    if (rst) begin
      m_valid = 1'b1;
      m_mode  = 0;
      m_cnt   = 0;
      m_wait  = 0;
      m_lvl   = 0;
      m_dir   = 3;
      m_pend  = 3;
      m_stall = 1'b0;
    end else if (m_valid) begin
      pend_old = m_pend;
      per = period_of(m_lvl);
      c = first_key();
      if (c >= 0 && c != opp[m_dir]) m_pend = c;
      if (lclr) m_lvl = 0;
      else if (score && m_lvl < (1 << LW) - 1) m_lvl++;
      case (m_mode)
        0: if (play) begin
          m_mode = 1;
          m_cnt  = 0;
        end
        1: if (!play) begin
          m_mode = 0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
          if (m_cnt >= per) begin
            m_mode = 2;
            m_dir  = pend_old;
            m_wait = 0;
          end
        end
        default: if (done) begin
          m_mode = play ? 1 : 0;
          m_cnt  = 0;
        end else if (m_wait < TO) begin
          m_wait++;
          if (m_wait == TO) m_stall = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("req", int'(req), (m_mode == 2) ? 1 : 0);
      chk("dir", int'(dir), m_dir);
      chk("level", int'(lvl), m_lvl);
      chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
      chk("stall", int'(stall), int'(m_stall));
    end
  end

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!req && n < 100);
    chk("req_seen", int'(req), 1);
  endtask

  task automatic step_done();
    @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
  endtask

  task automatic pulse_score(input int k);
    repeat (k) begin
      score = 1'b1;
      @(posedge clk);
      #1 score = 1'b0;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; st = 3'd0; done = 1'b0;
    key_u = 1'b0; key_d = 1'b0; key_l = 1'b0; key_r = 1'b0;
    score = 1'b0; lclr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", int'(req), 0);
    chk("rst_dir", int'(dir), 3);
    chk("rst_lvl", int'(lvl), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stall", int'(stall), 0);

    rst = 1'b0;
    st  = PLAY;
    wait_req(n);
    chk("first_latency", n, 11);
    chk("first_dir", int'(dir), 3);
    step_done();
    wait_req(n);
    chk("req_spacing", n + 2, 12);
    step_done();

    pulse_score(3);
    chk("lvl3", int'(lvl), 3);
    wait_req(n);
    step_done();
    wait_req(n);
    chk("period_l3", n, 4);
    step_done();
    pulse_score(2);
    chk("lvl5", int'(lvl), 5);
    wait_req(n);
    step_done();
    wait_req(n);
    chk("period_l5", n, 4);
    step_done();
    pulse_score(5);
    chk("lvl7_sat", int'(lvl), 7);
    wait_req(n);
    step_done();

    key_l = 1'b1;
    @(posedge clk);
    #1 key_l = 1'b0;
    wait_req(n);
    chk("dir_reverse_rej", int'(dir), 3);
    step_done();
    key_u = 1'b1; key_r = 1'b1;
    @(posedge clk);
    #1 key_u = 1'b0; key_r = 1'b0;
    wait_req(n);
    chk("dir_up", int'(dir), 0);
    step_done();

    lclr = 1'b1;
    @(posedge clk);
    #1 lclr = 1'b0;
    chk("lvl_clr", int'(lvl), 0);
    wait_req(n);
    step_done();
    repeat (3) @(posedge clk);
    #1 st = 3'd0;
    @(posedge clk);
    #1;
    chk("pause_busy", int'(busy), 0);
    repeat (5) begin
      @(posedge clk);
      #1 chk("pause_noreq", int'(req), 0);
    end
    st = PLAY;
    wait_req(n);
    chk("resume_latency", n, 11);

    repeat (7) @(posedge clk);
    #1 chk("stall_early", int'(stall), 0);
    @(posedge clk);
    #1;
    chk("stall_set", int'(stall), 1);
    chk("stall_req_held", int'(req), 1);
    step_done();
    chk("stall_done_req", int'(req), 0);
    repeat (3) @(posedge clk);
    #1 chk("stall_sticky", int'(stall), 1);

    pulse_score(1);
    wait_req(n);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_req_req", int'(req), 0);
    chk("rst_in_req_lvl", int'(lvl), 0);
    chk("rst_in_req_dir", int'(dir), 3);
    chk("rst_in_req_stall", int'(stall), 0);
    rst = 1'b0;
    pulse_score(1);
    chk("lvl1", int'(lvl), 1);
    score = 1'b1; lclr = 1'b1;
    @(posedge clk);
    #1 score = 1'b0; lclr = 1'b0;
    chk("clr_beats_score", int'(lvl), 0);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_step_scheduler.md
Name: game_step_scheduler

Overview:
- Paces the game datapath. While the game FSM is in its PLAY state, it issues one "step" request at a time to the game-logic block, at an interval set by the current speed level.
- Latches player direction from the four keys, with priority and a no-reversal rule, and commits it at each step.
- Manages speed level from score events and flags a stalled step handshake.
- Sits between game_fsm (state, keys) and the game update logic.

Parameters:
- PLAY_STATE, 3'd2, encoding of game_fsm state that enables stepping
- BASE_PERIOD, 12_500_000, cycles per step at level 0
- PERIOD_DEC, 500_000, cycles removed per level
- MIN_PERIOD, 2_500_000, floor on step period
- LEVEL_W, 4, width of speed level
- TIMEOUT, 1_000_000, max cycles oStep_req may stay high before stall flag

Ports:
- iClk  in  1  system clock; single clock domain
- iRst  in  1  synchronous, active-high reset
- iState  in  3  current game_fsm state
- iKey_up  in  1  debounced level, direction up
- iKey_down  in  1  debounced level, direction down
- iKey_left  in  1  debounced level, direction left
- iKey_right  in  1  debounced level, direction right
- iScore_evt  in  1  one-cycle pulse, raises level by 1
- iLevel_clr  in  1  one-cycle pulse, level to 0 (new game)
- iStep_done  in  1  game logic finished the current step
- oStep_req  out  1  step request, level, held until done
- oDir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right
- oLevel  out  LEVEL_W  current speed level
- oBusy  out  1  high in S_COUNT or S_REQ
- oStall  out  1  sticky: handshake exceeded TIMEOUT

Behaviour:
- Reset (iRst high at a clock edge), taking precedence over all other inputs:
  - state S_IDLE, oStep_req 0, oDir 2'b11, pending dir 2'b11, oLevel 0, oStall 0, counters 0.
- FSM S_IDLE:
  - Moves to S_COUNT when iState == PLAY_STATE is sampled.
  - Period counter is cleared on that transition.
- FSM S_COUNT:
  - Period counter increments each cycle.
  - When counter == period-1: go to S_REQ, oStep_req rises on that edge, and oDir loads pending dir on that same edge.
  - First oStep_req is therefore exactly `period` cycles after S_COUNT entry.
  - If iState != PLAY_STATE is sampled in S_COUNT: go to S_IDLE and clear the counter (pause; counter restarts on resume).
- FSM S_REQ:
  - oStep_req held high; oDir is stable.
  - On sampling iStep_done = 1: oStep_req drops on that edge, the counter clears, and the FSM moves to S_COUNT if iState == PLAY_STATE, else S_IDLE.
  - Leaving PLAY while in S_REQ never abandons the handshake.
  - iStep_done while not in S_REQ is ignored.
- Period:
  - Computed combinationally each cycle from oLevel in 32-bit unsigned arithmetic.
  - If oLevel*PERIOD_DEC >= BASE_PERIOD-MIN_PERIOD, period = MIN_PERIOD; else period = BASE_PERIOD - oLevel*PERIOD_DEC.
  - A level change mid-count takes effect immediately. If the counter is already >= new period-1, the request issues on the next cycle.
- Level:
  - iScore_evt increments the level, saturating at 2^LEVEL_W-1; it is accepted in any state.
  - iLevel_clr wins over iScore_evt in the same cycle.
- Direction:
  - Pending dir updates every cycle any key is high, regardless of FSM state.
  - Priority: up > down > left > right.
  - A candidate that is the opposite of the committed oDir is rejected and the pending value is kept. Opposite pairs: up/down, left/right.
  - Only the highest-priority pressed key is considered; there is no fallback to lower-priority keys.
  - With no key pressed, pending holds its value.
- Stall:
  - A wait counter runs while in S_REQ.
  - When it reaches TIMEOUT cycles with no done, oStall sets and stays set until iRst.
  - oStep_req stays high; the FSM keeps waiting.
- oBusy = (state != S_IDLE).

Test Plan (bench params: BASE_PERIOD=10, PERIOD_DEC=2, MIN_PERIOD=4, TIMEOUT=8, LEVEL_W=3, PLAY_STATE=2):
- Reset then iState=2 held, done returned 1 cycle after each req:
  - first oStep_req rises 10 cycles after S_COUNT entry, oDir=11.
  - subsequent reqs spaced 10 + 2 cycles.
- Three iScore_evt pulses → oLevel=3, period 4. Two more → oLevel=5, period clamps at 4. Five more → oLevel saturates at 7.
- Committed oDir=11 (right), press left → pending unchanged, next step oDir=11. Press up+right together → next step oDir=00.
- iState leaves 2 mid-count: FSM returns to S_IDLE, oBusy=0, no req. Return to 2: full 10-cycle count before req.
- Hold iStep_done=0 in S_REQ: oStall=1 after 8 cycles, oStep_req stays 1. Done then accepted; oStall remains 1 until iRst.
- iRst asserted during S_REQ: next cycle oStep_req=0, oLevel=0, oDir=11, oStall=0. iScore_evt and iLevel_clr in the same cycle: oLevel=0.
